risc_exec_ctrl: RTL and testbench

- Multi-cycle control FSM for the RISC datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALU operand-mux select: 00 = rt register, 01 = shift amount, 10 = sign-extended immediate.
- Drives the ALU function code, register-file write, memory strobes and PC update. Sits between the instruction register and the datapath muxes.

---
 rtl/risc_exec_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_risc_exec_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/risc_exec_ctrl.sv
// Multi-cycle control FSM for the RISC datapath: FETCH/DECODE/EXEC/MEM/WB with HALT.
// Optional retired/stall performance counters are enabled by defining RISC_PERF_CNT_EN.
module risc_exec_ctrl #(
    parameter int FUNC_W = 6,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FUNC_W-1:0] funct,
    input  logic              mem_ready,
    input  logic              alu_zero,
    output logic [1:0]        alu_src_sel,
    output logic [FUNC_W-1:0] alu_func,
    output logic              ir_write,
    output logic              pc_inc,
    output logic              pc_branch,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              reg_dst_rd,
    output logic              mem_to_reg,
    output logic              halted,
    output logic              illegal,
    output logic              instr_done
`ifdef RISC_PERF_CNT_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {C_R, C_IALU, C_LW, C_SW, C_BEQ, C_HALT, C_ILL} cls_t;

    localparam logic [OP_W-1:0]   OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0]   OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0]   OP_SLTI = OP_W'(6'b001010);
    localparam logic [OP_W-1:0]   OP_ANDI = OP_W'(6'b001100);
    localparam logic [OP_W-1:0]   OP_ORI  = OP_W'(6'b001101);
    localparam logic [OP_W-1:0]   OP_XORI = OP_W'(6'b001110);
    localparam logic [OP_W-1:0]   OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0]   OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0]   OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0]   OP_HALT = OP_W'(6'b111111);

    localparam logic [FUNC_W-1:0] F_SLL = FUNC_W'(6'b000000);
    localparam logic [FUNC_W-1:0] F_SRL = FUNC_W'(6'b000010);
    localparam logic [FUNC_W-1:0] F_SRA = FUNC_W'(6'b000011);
    localparam logic [FUNC_W-1:0] F_ADD = FUNC_W'(6'b100000);
    localparam logic [FUNC_W-1:0] F_SUB = FUNC_W'(6'b100010);
    localparam logic [FUNC_W-1:0] F_AND = FUNC_W'(6'b100100);
    localparam logic [FUNC_W-1:0] F_OR  = FUNC_W'(6'b100101);
    localparam logic [FUNC_W-1:0] F_XOR = FUNC_W'(6'b100110);
    localparam logic [FUNC_W-1:0] F_SLT = FUNC_W'(6'b101010);

    localparam logic [1:0] SEL_RT = 2'b00, SEL_SHAMT = 2'b01, SEL_IMM = 2'b10;

    state_t            state, state_nx;
    cls_t              cls_q, dec_cls;
    logic [OP_W-1:0]   op_q;
    logic [FUNC_W-1:0] fn_q, dec_func;
    logic [1:0]        dec_sel;
    logic              halt_entry;

    always_comb begin
        dec_cls  = C_ILL;
        dec_sel  = SEL_RT;
        dec_func = '0;
        case (op_q)
            OP_R: begin
                dec_cls  = C_R;
                dec_func = fn_q;
                dec_sel  = (fn_q == F_SLL || fn_q == F_SRL || fn_q == F_SRA) ? SEL_SHAMT : SEL_RT;
            end
            OP_ADDI: begin dec_cls = C_IALU; dec_sel = SEL_IMM; dec_func = F_ADD; end
            OP_SLTI: begin dec_cls = C_IALU; dec_sel = SEL_IMM; dec_func = F_SLT; end
            OP_ANDI: begin dec_cls = C_IALU; dec_sel = SEL_IMM; dec_func = F_AND; end
            OP_ORI:  begin dec_cls = C_IALU; dec_sel = SEL_IMM; dec_func = F_OR;  end
            OP_XORI: begin dec_cls = C_IALU; dec_sel = SEL_IMM; dec_func = F_XOR; end
            OP_LW:   begin dec_cls = C_LW;   dec_sel = SEL_IMM; dec_func = F_ADD; end
            OP_SW:   begin dec_cls = C_SW;   dec_sel = SEL_IMM; dec_func = F_ADD; end
            OP_BEQ:  begin dec_cls = C_BEQ;  dec_sel = SEL_RT;  dec_func = F_SUB; end
            OP_HALT: dec_cls = C_HALT;
            default: dec_cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = run ? S_FETCH : S_IDLE;
            S_FETCH:  state_nx = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (dec_cls == C_HALT)     state_nx = S_HALT;
                else if (dec_cls == C_ILL) state_nx = run ? S_FETCH : S_IDLE;
                else                       state_nx = S_EXEC;
            end
            S_EXEC: begin
                if (cls_q == C_BEQ)                         state_nx = run ? S_FETCH : S_IDLE;
                else if (cls_q == C_LW || cls_q == C_SW)    state_nx = S_MEM;
                else                                        state_nx = S_WB;
            end
            S_MEM: begin
                if (mem_ready) state_nx = (cls_q == C_LW) ? S_WB : (run ? S_FETCH : S_IDLE);
            end
            S_WB:     state_nx = run ? S_FETCH : S_IDLE;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        pc_inc     = 1'b0;
        pc_branch  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst_rd = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_inc   = mem_ready;
            end
            S_DECODE: instr_done = (dec_cls == C_ILL);
            S_EXEC: begin
                pc_branch  = (cls_q == C_BEQ) & alu_zero;
                instr_done = (cls_q == C_BEQ);
            end
            S_MEM: begin
                mem_read   = (cls_q == C_LW);
                mem_write  = (cls_q == C_SW);
                instr_done = (cls_q == C_SW) & mem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst_rd = (cls_q == C_R);
                mem_to_reg = (cls_q == C_LW);
                instr_done = 1'b1;
            end
            S_HALT: begin
                halted     = 1'b1;
                instr_done = halt_entry;
            end
            default: ;
        endcase
    end

    // Operand select and function code are captured at the end of DECODE and
    // cleared on any return to FETCH/IDLE so the fetch cycle always sees 00/0.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= '0;
            fn_q        <= '0;
            cls_q       <= C_ILL;
            alu_src_sel <= '0;
            alu_func    <= '0;
            illegal     <= 1'b0;
            halt_entry  <= 1'b0;
        end else begin
            if (state == S_FETCH && mem_ready) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (state == S_DECODE) begin
                cls_q       <= dec_cls;
                alu_src_sel <= dec_sel;
                alu_func    <= dec_func;
            end else if (state_nx == S_FETCH || state_nx == S_IDLE) begin
                alu_src_sel <= '0;
                alu_func    <= '0;
            end
            if (state == S_DECODE && dec_cls == C_ILL) illegal <= 1'b1;
            halt_entry <= (state == S_DECODE) && (dec_cls == C_HALT);
        end
    end

`ifdef RISC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (instr_done) retired_cnt <= retired_cnt + 32'd1;
            if ((state == S_FETCH || state == S_MEM) && !mem_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_risc_exec_ctrl.sv
// Scoreboard bench for risc_exec_ctrl: a responder plays memory, stimulus pushes
// expected per-instruction results, and a monitor checks them on every instr_done.
module tb_risc_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst, run, mem_ready, alu_zero;
    logic [5:0] opcode, funct;
    logic [1:0] alu_src_sel;
    logic [5:0] alu_func;
    logic       ir_write, pc_inc, pc_branch, mem_read, mem_write;
    logic       reg_write, reg_dst_rd, mem_to_reg, halted, illegal, instr_done;
`ifdef RISC_PERF_CNT_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    risc_exec_ctrl #(.FUNC_W(6), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .alu_zero(alu_zero),
        .alu_src_sel(alu_src_sel), .alu_func(alu_func), .ir_write(ir_write),
        .pc_inc(pc_inc), .pc_branch(pc_branch), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst_rd(reg_dst_rd),
        .mem_to_reg(mem_to_reg), .halted(halted), .illegal(illegal),
        .instr_done(instr_done)
`ifdef RISC_PERF_CNT_EN
        , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic [1:0] sel;
        logic [5:0] func;
        logic       dst, m2r, ill, hlt;
        int         lat, nrd, nwr, nrw, npb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fetch_stall = 0;
    int   mem_stall = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] sel, input logic [5:0] func,
                                input logic dst, input logic m2r, input logic ill,
                                input logic hlt, input int lat, input int nrd,
                                input int nwr, input int nrw, input int npb);
        exp_t e;
        e.sel = sel; e.func = func; e.dst = dst; e.m2r = m2r; e.ill = ill; e.hlt = hlt;
        e.lat = lat; e.nrd = nrd; e.nwr = nwr; e.nrw = nrw; e.npb = npb;
        return e;
    endfunction

    // Memory responder: fetch cycles see alu_func==0, MEM cycles see a nonzero code.
    always @(posedge clk) begin
        #2;
        mem_ready = 1'b1;
        if (mem_read || mem_write) begin
            if (alu_func == 6'd0 && fetch_stall > 0) begin
                mem_ready = 1'b0;
                fetch_stall--;
            end else if (alu_func != 6'd0 && mem_stall > 0) begin
                mem_ready = 1'b0;
                mem_stall--;
            end
        end
    end

    // Monitor: accumulates per-instruction activity and checks on instr_done.
    initial begin
        bit busy = 0;
        int lat = 0, nrd = 0, nwr = 0, nrw = 0, npb = 0, npi = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0; lat = 0; nrd = 0; nwr = 0; nrw = 0; npb = 0; npi = 0;
            end else begin
                chk("pc_inc_and_branch", int'(pc_inc & pc_branch), 0);
                chk("read_and_write", int'(mem_read & mem_write), 0);
                if (ir_write) begin
                    chk("fetch_sel_clear", int'(alu_src_sel), 0);
                    chk("fetch_func_clear", int'(alu_func), 0);
                end
                if (busy || mem_read) begin
                    busy = 1;
                    lat++;
                    nrd += int'(mem_read);
                    nwr += int'(mem_write);
                    nrw += int'(reg_write);
                    npb += int'(pc_branch);
                    npi += int'(pc_inc);
                end
                if (instr_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_instr_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("alu_src_sel", int'(alu_src_sel), int'(e.sel));
                        chk("alu_func", int'(alu_func), int'(e.func));
                        chk("reg_dst_rd", int'(reg_dst_rd), int'(e.dst));
                        chk("mem_to_reg", int'(mem_to_reg), int'(e.m2r));
                        chk("illegal", int'(illegal), int'(e.ill));
                        chk("halted", int'(halted), int'(e.hlt));
                        chk("latency", lat, e.lat);
                        chk("mem_read_cycles", nrd, e.nrd);
                        chk("mem_write_cycles", nwr, e.nwr);
                        chk("reg_write_cycles", nrw, e.nrw);
                        chk("pc_branch_cycles", npb, e.npb);
                        chk("pc_inc_cycles", npi, 1);
                    end
                    busy = 0; lat = 0; nrd = 0; nwr = 0; nrw = 0; npb = 0; npi = 0;
                end
            end
        end
    end

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (instr_done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input int fs, input int ms, input logic z, input exp_t e);
        opcode = op;
        funct = fn;
        fetch_stall = fs;
        mem_stall = ms;
        alu_zero = z;
        exp_q.push_back(e);
        wait_done(name);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, int'({alu_src_sel, alu_func, ir_write, pc_inc, pc_branch, mem_read,
                        mem_write, reg_write, reg_dst_rd, mem_to_reg, halted, illegal,
                        instr_done}), 0);
    endtask

    initial begin
        bit found = 0;
        rst = 1'b1; run = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_outputs");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;

        issue("sll",   6'b000000, 6'b000000, 0, 0, 1'b0, mk(2'b01, 6'b000000, 1, 0, 0, 0, 4, 1, 0, 1, 0));
        issue("addi",  6'b001000, 6'b000111, 0, 0, 1'b0, mk(2'b10, 6'b100000, 0, 0, 0, 0, 4, 1, 0, 1, 0));
        issue("add",   6'b000000, 6'b100000, 0, 0, 1'b0, mk(2'b00, 6'b100000, 1, 0, 0, 0, 4, 1, 0, 1, 0));
        issue("lw",    6'b100011, 6'b000000, 0, 3, 1'b0, mk(2'b10, 6'b100000, 0, 1, 0, 0, 8, 5, 0, 1, 0));
        issue("sw",    6'b101011, 6'b000000, 1, 2, 1'b0, mk(2'b10, 6'b100000, 0, 0, 0, 0, 7, 2, 3, 0, 0));
        issue("beq_t", 6'b000100, 6'b000000, 0, 0, 1'b1, mk(2'b00, 6'b100010, 0, 0, 0, 0, 3, 1, 0, 0, 1));
        issue("beq_n", 6'b000100, 6'b000000, 0, 0, 1'b0, mk(2'b00, 6'b100010, 0, 0, 0, 0, 3, 1, 0, 0, 0));
        issue("slti",  6'b001010, 6'b000000, 0, 0, 1'b0, mk(2'b10, 6'b101010, 0, 0, 0, 0, 4, 1, 0, 1, 0));
        issue("xori",  6'b001110, 6'b000000, 0, 0, 1'b0, mk(2'b10, 6'b100110, 0, 0, 0, 0, 4, 1, 0, 1, 0));
        issue("sra",   6'b000000, 6'b000011, 0, 0, 1'b0, mk(2'b01, 6'b000011, 1, 0, 0, 0, 4, 1, 0, 1, 0));
        // illegal is registered, so it reads high only from the following cycle
        issue("ill",   6'b010101, 6'b000000, 0, 0, 1'b0, mk(2'b00, 6'b000000, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        issue("halt",  6'b111111, 6'b000000, 0, 0, 1'b0, mk(2'b00, 6'b000000, 0, 0, 1, 1, 3, 1, 0, 0, 0));
`ifdef RISC_PERF_CNT_EN
        chk("retired_cnt", int'(retired_cnt), 12);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("halt_stays", int'({halted, mem_read, instr_done}), 3'b100);
        end
        chk("queue_drained", exp_q.size(), 0);

        run = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_from_halt");
        @(posedge clk);
        #1;
        rst = 1'b0;

        opcode = 6'b100011; funct = '0; mem_stall = 50; fetch_stall = 0;
        run = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_read && alu_func == 6'b100000) begin
                found = 1;
                break;
            end
        end
        chk("reach_lw_mem", int'(found), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_mid_mem_c1");
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_mid_mem_c2");
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_stall = 0;

        issue("addi2", 6'b001000, 6'b000000, 0, 0, 1'b0, mk(2'b10, 6'b100000, 0, 0, 0, 0, 4, 1, 0, 1, 0));
        chk("queue_empty_end", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
